// File: rtl/pio_fifo_pair.sv
// TX/RX FIFO pair for one PIO state machine: two banks of DEPTH words,
// optional join of both banks into one direction, flush, levels and sticky debug flags.
module pio_fifo_pair #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(2*DEPTH)+1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       join_mode,
  input  logic             flush,
  input  logic             tx_push,
  input  logic [WIDTH-1:0] tx_din,
  input  logic             m_pull,
  output logic [WIDTH-1:0] m_dout,
  input  logic             m_push,
  input  logic [WIDTH-1:0] m_din,
  input  logic             rx_pull,
  output logic [WIDTH-1:0] rx_dout,
  output logic             tx_full,
  output logic             tx_empty,
  output logic             rx_full,
  output logic             rx_empty,
  output logic [LW-1:0]    tx_level,
  output logic [LW-1:0]    rx_level,
  output logic [3:0]       dbg_flags,
  input  logic [3:0]       dbg_clr
);

  localparam int PW = $clog2(2*DEPTH);

  typedef enum logic [1:0] {
    MODE_SEP = 2'b00,
    MODE_TXJ = 2'b01,
    MODE_RXJ = 2'b10
  } mode_e;

  mode_e            mode;
  mode_e            mode_in;
  logic [WIDTH-1:0] mem [2*DEPTH];
  logic [PW-1:0]    tx_wr, tx_rd, rx_wr, rx_rd;
  logic [PW-1:0]    rx_base, rx_waddr, rx_raddr;
  logic [LW-1:0]    tx_cap, rx_cap, tx_cap_next, rx_cap_next;
  logic [LW-1:0]    tx_level_next, rx_level_next;
  logic             do_flush;
  logic             tx_push_acc, m_pull_acc, m_push_acc, rx_pull_acc;
  logic [3:0]       flag_set;

  function automatic logic [LW-1:0] cap_of(input mode_e m, input logic is_tx);
    case (m)
      MODE_TXJ: cap_of = is_tx ? LW'(2*DEPTH) : '0;
      MODE_RXJ: cap_of = is_tx ? '0 : LW'(2*DEPTH);
      default:  cap_of = LW'(DEPTH);
    endcase
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p, input logic [LW-1:0] cap);
    next_ptr = (LW'(p) == cap - LW'(1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mode_in = MODE_SEP;
    if (join_mode != 2'b11) mode_in = mode_e'(join_mode);
  end

  // A change of effective mode behaves exactly like an explicit flush on that edge.
  assign do_flush    = flush | (mode_in != mode);
  assign tx_cap      = cap_of(mode, 1'b1);
  assign rx_cap      = cap_of(mode, 1'b0);
  assign tx_cap_next = cap_of(mode_in, 1'b1);
  assign rx_cap_next = cap_of(mode_in, 1'b0);

  assign tx_push_acc = tx_push & ~tx_full  & ~do_flush;
  assign m_pull_acc  = m_pull  & ~tx_empty & ~do_flush;
  assign m_push_acc  = m_push  & ~rx_full  & ~do_flush;
  assign rx_pull_acc = rx_pull & ~rx_empty & ~do_flush;

  assign flag_set[0] = m_push  & rx_full  & ~do_flush;
  assign flag_set[1] = rx_pull & rx_empty & ~do_flush;
  assign flag_set[2] = tx_push & tx_full  & ~do_flush;
  assign flag_set[3] = m_pull  & tx_empty & ~do_flush;

  assign tx_level_next = do_flush ? '0 : tx_level + LW'(tx_push_acc) - LW'(m_pull_acc);
  assign rx_level_next = do_flush ? '0 : rx_level + LW'(m_push_acc) - LW'(rx_pull_acc);

  // Unjoined RX lives in bank B; joined RX spans both banks from address 0.
  assign rx_base  = (mode == MODE_RXJ) ? '0 : PW'(DEPTH);
  assign rx_waddr = rx_wr + rx_base;
  assign rx_raddr = rx_rd + rx_base;

  assign m_dout  = tx_empty ? '0 : mem[tx_rd];
  assign rx_dout = rx_empty ? '0 : mem[rx_raddr];

  always_ff @(posedge clk) begin
    if (tx_push_acc) mem[tx_wr] <= tx_din;
    if (m_push_acc)  mem[rx_waddr] <= m_din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode      <= MODE_SEP;
      tx_wr     <= '0;
      tx_rd     <= '0;
      rx_wr     <= '0;
      rx_rd     <= '0;
      tx_level  <= '0;
      rx_level  <= '0;
      tx_full   <= 1'b0;
      tx_empty  <= 1'b1;
      rx_full   <= 1'b0;
      rx_empty  <= 1'b1;
      dbg_flags <= '0;
    end else begin
      mode      <= mode_in;
      tx_level  <= tx_level_next;
      rx_level  <= rx_level_next;
      tx_full   <= (tx_level_next == tx_cap_next);
      tx_empty  <= (tx_level_next == '0);
      rx_full   <= (rx_level_next == rx_cap_next);
      rx_empty  <= (rx_level_next == '0);
      dbg_flags <= (dbg_flags & ~dbg_clr) | flag_set;
      if (do_flush) begin
        tx_wr <= '0;
        tx_rd <= '0;
        rx_wr <= '0;
        rx_rd <= '0;
      end else begin
        if (tx_push_acc) tx_wr <= next_ptr(tx_wr, tx_cap);
        if (m_pull_acc)  tx_rd <= next_ptr(tx_rd, tx_cap);
        if (m_push_acc)  rx_wr <= next_ptr(rx_wr, rx_cap);
        if (rx_pull_acc) rx_rd <= next_ptr(rx_rd, rx_cap);
      end
    end
  end

endmodule

// File: tb/tb_pio_fifo_pair.sv
// Self-checking bench for pio_fifo_pair: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_pio_fifo_pair;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(2*DEPTH)+1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       join_mode;
  logic             flush, tx_push, m_pull, m_push, rx_pull;
  logic [WIDTH-1:0] tx_din, m_din, m_dout, rx_dout;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0]    tx_level, rx_level;
  logic [3:0]       dbg_flags, dbg_clr;

  int checks   = 0;
  int failures = 0;

  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  int          mmode;
  logic [3:0]  mflags;

  pio_fifo_pair #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset_n(reset_n), .join_mode(join_mode), .flush(flush),
    .tx_push(tx_push), .tx_din(tx_din), .m_pull(m_pull), .m_dout(m_dout),
    .m_push(m_push), .m_din(m_din), .rx_pull(rx_pull), .rx_dout(rx_dout),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_full(rx_full), .rx_empty(rx_empty),
    .tx_level(tx_level), .rx_level(rx_level), .dbg_flags(dbg_flags), .dbg_clr(dbg_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic int capOf(input int md, input bit is_tx);
    if (md == 1) return is_tx ? 2*DEPTH : 0;
    if (md == 2) return is_tx ? 0 : 2*DEPTH;
    return DEPTH;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    int tc, rc;
    tc = capOf(mmode, 1'b1);
    rc = capOf(mmode, 1'b0);
    checkOutput("tx_level", 32'(tx_level), 32'(txq.size()));
    checkOutput("rx_level", 32'(rx_level), 32'(rxq.size()));
    checkOutput("tx_empty", 32'(tx_empty), 32'(txq.size() == 0));
    checkOutput("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
    checkOutput("tx_full",  32'(tx_full),  32'(txq.size() == tc));
    checkOutput("rx_full",  32'(rx_full),  32'(rxq.size() == rc));
    checkOutput("m_dout",   m_dout,  (txq.size() > 0) ? txq[0] : 32'h0);
    checkOutput("rx_dout",  rx_dout, (rxq.size() > 0) ? rxq[0] : 32'h0);
    checkOutput("dbg_flags", 32'(dbg_flags), 32'(mflags));
  endtask

  task automatic resetModel();
    txq.delete();
    rxq.delete();
    mmode  = 0;
    mflags = 4'h0;
  endtask

  task automatic modelEdge(input logic tp, input logic [31:0] td, input logic mpl,
                           input logic mps, input logic [31:0] md, input logic rp,
                           input logic fl, input logic [3:0] clr);
    int eff, tc, rc;
    bit tfull, tempty, rfull, rempty;
    logic [3:0] set;
    eff = (join_mode == 2'b11) ? 0 : int'(join_mode);
    if (fl || eff != mmode) begin
      txq.delete();
      rxq.delete();
      mmode  = eff;
      mflags = mflags & ~clr;
    end else begin
      tc = capOf(mmode, 1'b1);
      rc = capOf(mmode, 1'b0);
      tfull  = (txq.size() == tc);
      tempty = (txq.size() == 0);
      rfull  = (rxq.size() == rc);
      rempty = (rxq.size() == 0);
      set = 4'h0;
      if (mps && rfull)  set[0] = 1'b1;
      if (rp && rempty)  set[1] = 1'b1;
      if (tp && tfull)   set[2] = 1'b1;
      if (mpl && tempty) set[3] = 1'b1;
      if (mpl && !tempty) void'(txq.pop_front());
      if (tp && !tfull)   txq.push_back(td);
      if (rp && !rempty)  void'(rxq.pop_front());
      if (mps && !rfull)  rxq.push_back(md);
      mflags = (mflags & ~clr) | set;
    end
  endtask

  // One clock of stimulus: drive, clock, update the model, compare, return to idle.
  task automatic applyStimulus(input logic tp, input logic [31:0] td, input logic mpl,
                               input logic mps, input logic [31:0] md, input logic rp,
                               input logic fl, input logic [3:0] clr);
    tx_push = tp; tx_din = td; m_pull = mpl; m_push = mps; m_din = md;
    rx_pull = rp; flush = fl; dbg_clr = clr;
    @(posedge clk);
    modelEdge(tp, td, mpl, mps, md, rp, fl, clr);
    #1;
    checkAll();
    tx_push = 0; m_pull = 0; m_push = 0; rx_pull = 0; flush = 0; dbg_clr = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0; join_mode = 2'b00; flush = 0; tx_push = 0; tx_din = '0;
    m_pull = 0; m_push = 0; m_din = '0; rx_pull = 0; dbg_clr = 4'h0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    reset_n = 1'b1;

    // Unjoined fill past full, then drain in order
    for (int i = 1; i <= 5; i++) applyStimulus(1, 32'h11 * i, 0, 0, 0, 0, 0, 0);
    checkOutput("tp1_tx_level", 32'(tx_level), 32'd4);
    checkOutput("tp1_tx_full", 32'(tx_full), 32'd1);
    checkOutput("tp1_tx_over", 32'(dbg_flags[2]), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("tp1_head", m_dout, 32'h11 * i);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    end
    checkOutput("tp1_tx_empty", 32'(tx_empty), 32'd1);
    checkOutput("tp1_m_dout_zero", m_dout, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'hF);

    // TX joined: 8 deep, RX has no storage
    join_mode = 2'b01;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 32'hA0 + i, 0, 0, 0, 0, 0, 0);
    checkOutput("tp2_tx_level", 32'(tx_level), 32'd8);
    checkOutput("tp2_tx_full", 32'(tx_full), 32'd1);
    checkOutput("tp2_rx_full", 32'(rx_full), 32'd1);
    checkOutput("tp2_rx_empty", 32'(rx_empty), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'hDEAD, 0, 0, 0);
    checkOutput("tp2_rx_stall", 32'(dbg_flags[0]), 32'd1);
    applyStimulus(1, 32'hBAD, 0, 0, 0, 0, 0, 0);
    checkOutput("tp2_tx_over", 32'(dbg_flags[2]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("tp2_head", m_dout, 32'hA0 + i);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    end

    // Back to separate; simultaneous push and pull at levels 0, 2 and 4
    join_mode = 2'b00;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'hF);
    applyStimulus(1, 32'h77, 1, 0, 0, 0, 0, 0);
    checkOutput("tp3_level0", 32'(tx_level), 32'd1);
    checkOutput("tp3_tx_stall", 32'(dbg_flags[3]), 32'd1);
    checkOutput("tp3_bypass_head", m_dout, 32'h77);
    applyStimulus(1, 32'h78, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h79, 1, 0, 0, 0, 0, 0);
    checkOutput("tp3_level2", 32'(tx_level), 32'd2);
    applyStimulus(1, 32'h7A, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h7B, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h7C, 1, 0, 0, 0, 0, 0);
    checkOutput("tp3_level4", 32'(tx_level), 32'd3);

    // RX wrap-around with alternating push/pull
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'hF);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h100 + i, 0, 0, 0);
      checkOutput("tp4_head", rx_dout, 32'h100 + i);
      checkOutput("tp4_level_bound", 32'(rx_level <= 4), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    end
    checkOutput("tp4_no_flags", 32'(dbg_flags), 32'h0);

    // Set beats same-cycle clear
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 4'hF);
    checkOutput("tp5_set_wins", 32'(dbg_flags), 32'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'h2);
    checkOutput("tp5_cleared", 32'(dbg_flags), 32'h0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'hC0 + i, 0, 0, 0, 0, 0, 0);
    tx_push = 1; tx_din = 32'hCC;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("tp6_level", 32'(tx_level), 32'd0);
    checkOutput("tp6_empty", 32'(tx_empty), 32'd1);
    checkOutput("tp6_m_dout", m_dout, 32'h0);
    resetModel();
    tx_push = 0;
    #1 reset_n = 1'b1;
    applyStimulus(1, 32'hE1, 0, 0, 0, 0, 0, 0);
    checkOutput("tp6_after", m_dout, 32'hE1);

    // Random traffic including mode changes and flushes
    for (int n = 0; n < 600; n++) begin
      logic [3:0] clr;
      if ($urandom_range(0, 39) == 0) join_mode = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
                    1'($urandom), ($urandom_range(0, 49) == 0), clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_fifo_pair.md
# pio_fifo_pair

Parametrised TX/RX FIFO pair for one PIO state machine, the next generation of the fixed 4-deep per-machine FIFOs. It sits between the host register interface (TX push, RX pull) and one machine (TX pull, RX push). It adds:
- configurable width and depth;
- RP2040-style join modes, which give one direction both banks of storage;
- flush;
- per-direction levels;
- sticky overflow, underflow and stall debug flags.

## Interface
Parameters:
- WIDTH, default 32: data word width.
- DEPTH, default 4: entries per direction when unjoined. Must be a power of two, at least 2.
- LW, default $clog2(2*DEPTH)+1: level width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- join  in  2  mode: 00 = separate, 01 = TX joined (TX depth 2*DEPTH, RX depth 0), 10 = RX joined (RX depth 2*DEPTH, TX depth 0), 11 = treated as 00.
- flush  in  1  empties both FIFOs.
- tx_push  in  1  host writes tx_din.
- tx_din  in  WIDTH  host TX data.
- m_pull  in  1  machine pops TX head.
- m_dout  out  WIDTH  TX head; 0 when TX is empty.
- m_push  in  1  machine writes m_din.
- m_din  in  WIDTH  machine RX data.
- rx_pull  in  1  host pops RX head.
- rx_dout  out  WIDTH  RX head; 0 when RX is empty.
- tx_full, tx_empty, rx_full, rx_empty  out  1 each  registered status.
- tx_level, rx_level  out  LW each  registered occupancy.
- dbg_flags  out  4  sticky flags: [0] rx_stall, [1] rx_under, [2] tx_over, [3] tx_stall.
- dbg_clr  in  4  write-one-to-clear for dbg_flags.

## Operation
- Storage is two banks of DEPTH words each.
  - Unjoined: bank A is TX, bank B is RX.
  - Joined: the selected direction addresses both banks as one 2*DEPTH circular buffer.
- Capacity per direction is DEPTH, 2*DEPTH or 0, set by the registered effective mode.
- A capacity-0 direction reports full=1, empty=1, level=0 and dout=0.
  - Every push to it is dropped and flagged.
  - Every pull from it is ignored and flagged.
- Mode change:
  - join is registered into an effective mode.
  - When the registered value differs from the incoming one, both FIFOs are flushed on that edge, the same as flush=1.
- Flush: read/write pointers and levels go to 0. Any push or pull in the flush cycle is ignored, and no flags are set.
- Accept rules use pre-edge status:
  - A push is accepted iff !full. Otherwise it is dropped.
  - A pull is accepted iff !empty. Otherwise it is ignored.
  - A simultaneous push and pull are evaluated independently:
    - at level 0: push accepted, pull ignored and flagged (no bypass);
    - when full: pull accepted, push dropped and flagged;
    - otherwise both are accepted and the level is unchanged.
- Level: level_next = level + push_acc - pull_acc. It never exceeds capacity and never wraps.
- Pointers are (log2(2*DEPTH))-bit and wrap modulo capacity.
  - Unjoined: the RX pointer offsets by DEPTH into bank B.
- Flags:
  - tx_over is set by a dropped tx_push.
  - tx_stall is set by an ignored m_pull.
  - rx_stall is set by a dropped m_push.
  - rx_under is set by an ignored rx_pull.
  - Set wins over a same-cycle dbg_clr.

## Timing
- Reset (async assert, sync release) values:
  - levels 0, empty=1, full=0;
  - dbg_flags 0, effective mode 00, pointers 0;
  - m_dout and rx_dout 0.
  - Storage is not reset.
- Push at edge N:
  - level, empty and full update at edge N;
  - the word is visible on dout during cycle N+1 if it is the head.
  - Push-to-pull latency is 1 cycle.
- dout is a combinational read of the head entry, masked to 0 by registered empty.
- A pull at edge N advances the head. The new head is visible in cycle N+1.
- A join change seen at edge N flushes at edge N. The new capacities apply from cycle N+1.
- Asserting reset_n low mid-operation clears state immediately; no partial writes survive.

## Test plan
- Reset, unjoined, DEPTH=4: push 0x11..0x55 on TX → tx_full after the 4th push, 5th dropped, tx_over=1, tx_level=4; m_pull x4 returns 0x11,0x22,0x33,0x44 in order, then tx_empty=1 and m_dout=0.
- Set join=01: flush at that edge; push 8 words → tx_level=8 with tx_full; rx_full=1 and rx_empty=1; m_push sets rx_stall; 9th tx_push sets tx_over; pulls return all 8 words in order.
- Simultaneous push and pull at levels 0, 2 and 4 (DEPTH=4) → levels 1, 2 and 3 respectively; at level 0, tx_stall=1 and m_dout shows the pushed word one cycle later.
- Wrap-around: 20 alternating push/pull pairs with an incrementing pattern on RX → data intact, rx_level stays within 0..4, no flags set.
- dbg_clr=0xF in the same cycle as an rx_pull on empty RX → rx_under stays 1, other flags clear; the next dbg_clr=0x2 clears it.
- reset_n pulsed low while TX holds 3 words and a push is in flight → tx_level=0, tx_empty=1 and m_dout=0 immediately; after release, a push works normally.
